// File: rtl/core_sequencer_pkg.sv
// Shared widths, step size and state encoding for the npc core sequencer.
package core_sequencer_pkg;

    localparam int INST_ADDR_WIDTH = 32;
    localparam int INST_WIDTH      = 32;

    localparam logic [INST_ADDR_WIDTH-1:0] INST_STEP = INST_ADDR_WIDTH'(4);

    typedef enum logic [1:0] {
        SEQ_FETCH = 2'd0,
        SEQ_WAIT  = 2'd1,
        SEQ_EXEC  = 2'd2,
        SEQ_HALT  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/WAIT/EXEC/HALT sequencer: owns PC and IR, gates the RF
// write strobe to one cycle per retired instruction, and counts retirements.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_req_o,
    output logic [INST_ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                       imem_ready_i,
    input  logic                       imem_rvalid_i,
    input  logic [INST_WIDTH-1:0]      imem_rdata_i,
    output logic [INST_ADDR_WIDTH-1:0] pc_o,
    output logic [INST_WIDTH-1:0]      inst_o,
    output logic                       inst_valid_o,
    input  logic                       wena_i,
    input  logic                       ebreak_i,
    input  logic                       jump_i,
    input  logic [INST_ADDR_WIDTH-1:0] jump_target_i,
    output logic                       rf_we_o,
    output logic                       halt_o,
    output logic                       err_o,
    output logic [31:0]                instret_o
);

    seq_state_e                 state;
    logic [INST_ADDR_WIDTH-1:0] next_pc;
    logic                       bad_target;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        next_pc    = jump_i ? jump_target_i : pc_o + INST_STEP;
        bad_target = jump_i && (jump_target_i[1:0] != 2'b00);
    end

    // The request is masked while rst is high so the reset cycle never issues a fetch.
    assign imem_req_o   = (state == SEQ_FETCH) && !rst;
    assign imem_addr_o  = pc_o;
    assign inst_valid_o = (state == SEQ_EXEC);
    assign rf_we_o      = inst_valid_o && wena_i && !ebreak_i && !bad_target;

    // NOTE: state registers use non-blocking assignments so every update lands on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SEQ_FETCH;
            pc_o      <= RESET_PC;
            inst_o    <= '0;
            halt_o    <= 1'b0;
            err_o     <= 1'b0;
            instret_o <= '0;
        end else begin
            case (state)
                SEQ_FETCH: begin
                    // rvalid here belongs to a fetch abandoned by reset and is dropped.
                    if (imem_ready_i) state <= SEQ_WAIT;
                end
                SEQ_WAIT: begin
                    if (imem_rvalid_i) begin
                        inst_o <= imem_rdata_i;
                        state  <= SEQ_EXEC;
                    end
                end
                SEQ_EXEC: begin
                    if (ebreak_i) begin
                        halt_o    <= 1'b1;
                        instret_o <= instret_o + 32'd1;
                        state     <= SEQ_HALT;
                    end else if (bad_target) begin
                        halt_o <= 1'b1;
                        err_o  <= 1'b1;
                        state  <= SEQ_HALT;
                    end else begin
                        pc_o      <= next_pc;
                        instret_o <= instret_o + 32'd1;
                        state     <= SEQ_FETCH;
                    end
                end
                default: state <= SEQ_HALT;
            endcase
        end
    end

endmodule
